seq_chunk_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor that computes a WIDTH-bit sum CHUNK bits per clock, LSB slice first, with a registered carry between slices. It is the successor of the team's fixed 4-bit ripple-carry adder. It adds arbitrary operand width, a subtract mode and a signed-overflow flag, and uses valid/ready handshakes so it can be placed between pipelined datapath stages where a wide single-cycle ripple would not meet timing.

---
 rtl/seq_chunk_adder.sv | 110 +++++++++++
 tb/tb_seq_chunk_adder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit result built CHUNK bits per clock,
// LSB slice first, with a registered carry between slices and valid/ready handshakes.
module seq_chunk_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] b_p0;
   logic             carry;
   logic [31:0]      lo;
   logic [CHUNK-1:0] a_sl;
   logic [CHUNK-1:0] b_sl;
   logic [CHUNK-1:0] s_sl;
   logic [CHUNK:0]   c_sl;
   logic [WIDTH-1:0] sum_nxt;

   // c[i] is the carry into bit i of the slice; c[CHUNK] is the slice carry-out.
   function automatic logic [CHUNK:0] ripple_carries(input logic [CHUNK-1:0] x,
                                                     input logic [CHUNK-1:0] y,
                                                     input logic             ci);
      logic [CHUNK:0] c;
      c[0] = ci;
      for (int i = 0; i < CHUNK; i++)
         c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
      return c;
   endfunction

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_comb begin
      lo      = 32'(idx) * CHUNK;
      a_sl    = CHUNK'(a_p0 >> lo);
      b_sl    = CHUNK'(b_p0 >> lo);
      c_sl    = ripple_carries(a_sl, b_sl, carry);
      s_sl    = a_sl ^ b_sl ^ c_sl[CHUNK-1:0];
      sum_nxt = (sum & ~(SLICE_MASK << lo)) | (WIDTH'(s_sl) << lo);
   end

   // Operand capture: B is pre-inverted for subtract so RUN only ever adds.
   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         a_p0 <= a;
         b_p0 <= b ^ {WIDTH{sub}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         carry <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state <= RUN;
                  idx   <= '0;
                  carry <= cin ^ sub;
               end
            end
            RUN: begin
               sum   <= sum_nxt;
               carry <= c_sl[CHUNK];
               idx   <= idx + IW'(1);
               if (idx == LAST) begin
                  cout  <= c_sl[CHUNK];
                  ovf   <= c_sl[CHUNK-1] ^ c_sl[CHUNK];
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Scoreboard bench for seq_chunk_adder: CHUNK=4 directed cases plus CHUNK=16
// and CHUNK=1 instances for latency and random sweeps against a reference model.
module tb_seq_chunk_adder;

   typedef logic [17:0] exp_t;   // {ovf, cout, sum}

   logic        clk = 1'b0;
   logic        rst;
   logic        iv[3], ir[3], ov[3], ordy[3], ci[3], sb[3], co[3], of[3], by[3];
   logic [15:0] ia[3], ib[3], sm[3];
   exp_t        expq[3][$];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         localparam int CH = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
         seq_chunk_adder #(.WIDTH(16), .CHUNK(CH)) u_dut (
            .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]),
            .a(ia[g]), .b(ib[g]), .cin(ci[g]), .sub(sb[g]),
            .out_valid(ov[g]), .out_ready(ordy[g]), .sum(sm[g]),
            .cout(co[g]), .ovf(of[g]), .busy(by[g]));

         always @(negedge clk) begin : mon
            exp_t e;
            if (!rst && ov[g] && ordy[g]) begin
               total++;
               if (expq[g].size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_result[%0d] got sum=%h cout=%b ovf=%b, required no result",
                           g, sm[g], co[g], of[g]);
               end else begin
                  e = expq[g].pop_front();
                  if ({of[g], co[g], sm[g]} !== e) begin
                     bad++;
                     $display("FAIL result[%0d] got ovf=%b cout=%b sum=%h, required ovf=%b cout=%b sum=%h",
                              g, of[g], co[g], sm[g], e[17], e[16], e[15:0]);
                  end
               end
            end
         end
      end
   endgenerate

   function automatic exp_t refm(input logic [15:0] xa, input logic [15:0] xb,
                                 input logic xc, input logic xs);
      logic [15:0] bb;
      logic [16:0] f;
      logic        v;
      bb = xs ? ~xb : xb;
      f  = {1'b0, xa} + {1'b0, bb} + 17'(xc ^ xs);
      v  = (xa[15] == bb[15]) && (f[15] != xa[15]);
      return {v, f[16], f[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s got %h required %h", nm, act, req);
      end
   endtask

   task automatic issue(input int i, input logic [15:0] xa, input logic [15:0] xb,
                        input logic xc, input logic xs, input bit push, input exp_t e);
      bit ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (ir[i]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL in_ready_timeout[%0d] got in_ready=0 required 1", i);
         return;
      end
      ia[i] = xa; ib[i] = xb; ci[i] = xc; sb[i] = xs; iv[i] = 1'b1;
      if (push) expq[i].push_back(e);
      @(posedge clk);
      #1 iv[i] = 1'b0;
   endtask

   task automatic lat_run(input int i, input logic [15:0] xa, input logic [15:0] xb,
                          input logic xc, input logic xs, input exp_t e, input int req);
      int lat = 0;
      bit irbad = 1'b0;
      issue(i, xa, xb, xc, xs, 1'b1, e);
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (ir[i]) irbad = 1'b1;
         if (ov[i]) break;
      end
      chk($sformatf("latency[%0d]", i), 32'(lat), 32'(req));
      chk($sformatf("in_ready_low_during_op[%0d]", i), 32'(irbad), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; ia[i] = '0; ib[i] = '0; ci[i] = 1'b0; sb[i] = 1'b0; ordy[i] = 1'b1;
      end
      #2 rst = 1'b1;
      #2;
      chk("rst_in_ready", 32'(ir[0]), 32'd1);
      chk("rst_out_valid", 32'(ov[0]), 32'd0);
      chk("rst_busy", 32'(by[0]), 32'd0);
      chk("rst_sum", 32'(sm[0]), 32'h0);
      chk("rst_cout", 32'(co[0]), 32'd0);
      chk("rst_ovf", 32'(of[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // add cases, with latency measured on the first
      lat_run(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, {2'b00, 16'h0100}, 4);
      issue(0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, {2'b01, 16'h0001});
      issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {2'b10, 16'h8000});
      // subtract cases
      issue(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, {2'b00, 16'hFFFE});
      issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, {2'b11, 16'h7FFF});
      issue(0, 16'h0010, 16'h0001, 1'b1, 1'b1, 1'b1, {2'b01, 16'h000E});

      // backpressure
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (expq[0].size() == 0 && ir[0]) break;
      end
      ordy[0] = 1'b0;
      issue(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, {2'b00, 16'h5555});
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (ov[0]) break;
      end
      chk("bp_out_valid_rise", 32'(ov[0]), 32'd1);
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         iv[0] = ~iv[0]; ia[0] = 16'($urandom); ib[0] = 16'($urandom);
         sb[0] = ~sb[0]; ci[0] = ~ci[0];
         @(negedge clk);
         chk("bp_sum", 32'(sm[0]), 32'h5555);
         chk("bp_cout", 32'(co[0]), 32'd0);
         chk("bp_ovf", 32'(of[0]), 32'd0);
         chk("bp_in_ready", 32'(ir[0]), 32'd0);
         chk("bp_out_valid", 32'(ov[0]), 32'd1);
      end
      @(posedge clk);
      #1;
      iv[0] = 1'b0; sb[0] = 1'b0; ci[0] = 1'b0; ordy[0] = 1'b1;
      repeat (4) @(negedge clk);
      chk("bp_no_restart_busy", 32'(by[0]), 32'd0);
      chk("bp_queue_drained", 32'(expq[0].size()), 32'd0);

      // reset in the middle of an operation (after E2)
      issue(0, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_in_ready", 32'(ir[0]), 32'd1);
      chk("abort_out_valid", 32'(ov[0]), 32'd0);
      chk("abort_sum", 32'(sm[0]), 32'h0);
      chk("abort_busy", 32'(by[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_no_out_valid", 32'(ov[0]), 32'd0);
      issue(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1, {2'b00, 16'h1010});
      issue(0, 16'h0003, 16'h0004, 1'b1, 1'b1, 1'b1, {2'b00, 16'hFFFE});

      // single-slice and single-bit configurations: latency, then random sweeps
      lat_run(1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, {2'b10, 16'h8000}, 1);
      lat_run(2, 16'h8000, 16'h0001, 1'b0, 1'b1, {2'b11, 16'h7FFF}, 16);
      fork
         begin
            for (int m = 0; m < 2; m++)
               for (int n = 0; n < 1000; n++) begin
                  logic [15:0] xa, xb;
                  logic xc;
                  xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom);
                  issue(1, xa, xb, xc, 1'(m), 1'b1, refm(xa, xb, xc, 1'(m)));
               end
         end
         begin
            for (int m = 0; m < 2; m++)
               for (int n = 0; n < 1000; n++) begin
                  logic [15:0] xa, xb;
                  logic xc;
                  xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom);
                  issue(2, xa, xb, xc, 1'(m), 1'b1, refm(xa, xb, xc, 1'(m)));
               end
         end
      join

      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (expq[0].size() == 0 && expq[1].size() == 0 && expq[2].size() == 0) break;
      end
      chk("drain_q0", 32'(expq[0].size()), 32'd0);
      chk("drain_q1", 32'(expq[1].size()), 32'd0);
      chk("drain_q2", 32'(expq[2].size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
